lc3_ctrl_fsm: RTL and testbench

Multicycle control unit for the LC-3 datapath. It sequences instruction fetch, decode and execute by driving the load enables, bus gates and mux selects of the PC/MAR/MDR/IR registers, the memory port, and the 8×16 register file. It drives the regfile write enable and the DR/SR1/SR2 addresses. It supports ADD, AND, NOT, LEA, LD, ST, BR, JMP and TRAP. TRAP, and any other opcode, is treated as halt. It sits between the IR/condition-code flags and the datapath control pins.

---
 rtl/lc3_ctrl_pkg.sv | 87 ++++++++
 rtl/lc3_ctrl_fsm_decode.sv | 94 +++++++++
 rtl/lc3_ctrl_fsm.sv | 92 +++++++++
 tb/tb_lc3_ctrl_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the LC-3 multicycle control unit: states, opcodes,
// datapath mux selects and the bundled control-word payload.
package lc3_ctrl_pkg;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_ALU  = 4'd5,
        S_LEA  = 4'd6,
        S_LD1  = 4'd7,
        S_LD2  = 4'd8,
        S_LD3  = 4'd9,
        S_ST1  = 4'd10,
        S_ST2  = 4'd11,
        S_ST3  = 4'd12,
        S_BR   = 4'd13,
        S_JMP  = 4'd14,
        S_HALT = 4'd15
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [SEL_W-1:0] GATE_PC     = 2'd0;
    localparam logic [SEL_W-1:0] GATE_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] GATE_ALU    = 2'd2;
    localparam logic [SEL_W-1:0] GATE_MARMUX = 2'd3;

    localparam logic [SEL_W-1:0] PCMUX_INC   = 2'd0;
    localparam logic [SEL_W-1:0] PCMUX_OFF9  = 2'd1;
    localparam logic [SEL_W-1:0] PCMUX_BASER = 2'd2;

    localparam logic MARMUX_OFF9 = 1'b0;
    localparam logic MARMUX_PC   = 1'b1;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'd0;
    localparam logic [SEL_W-1:0] ALU_AND   = 2'd1;
    localparam logic [SEL_W-1:0] ALU_NOT   = 2'd2;
    localparam logic [SEL_W-1:0] ALU_PASSA = 2'd3;

    typedef struct packed {
        logic              ld_pc;
        logic              ld_mar;
        logic              ld_mdr;
        logic              ld_ir;
        logic              ld_cc;
        logic              reg_we;
        logic [REG_AW-1:0] dr;
        logic [REG_AW-1:0] sr1;
        logic [REG_AW-1:0] sr2;
        logic [SEL_W-1:0]  gate_sel;
        logic [SEL_W-1:0]  pcmux_sel;
        logic              marmux_sel;
        logic [SEL_W-1:0]  alu_op;
        logic              mem_en;
        logic              mem_we;
        logic              halted;
    } ctrl_t;

    // First execute state for an opcode; anything unsupported halts.
    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            OP_ADD, OP_AND, OP_NOT: dispatch = S_ALU;
            OP_LEA:                 dispatch = S_LEA;
            OP_LD:                  dispatch = S_LD1;
            OP_ST:                  dispatch = S_ST1;
            OP_BR:                  dispatch = S_BR;
            OP_JMP:                 dispatch = S_JMP;
            default:                dispatch = S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_decode.sv
// Moore control-word decode: maps the current state and IR onto the
// datapath load enables, bus gates, mux selects and memory strobes.
module lc3_ctrl_fsm_decode
    import lc3_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [IR_W-1:0] ir,
    input  logic            cc_n,
    input  logic            cc_z,
    input  logic            cc_p,
    output ctrl_t           ctrl
);

    logic br_taken;
    logic unused_ir_bits;

    assign br_taken       = (ir[11] & cc_n) | (ir[10] & cc_z) | (ir[9] & cc_p);
    assign unused_ir_bits = ^ir[5:3];

    always_comb begin
        ctrl = '0;
        // Register addresses are quiet while idle or halted so reset shows all zeros.
        if (state != S_IDLE && state != S_HALT) begin
            ctrl.dr  = ir[11:9];
            ctrl.sr1 = ir[8:6];
            ctrl.sr2 = ir[2:0];
        end
        case (state)
            S_F1: begin
                ctrl.ld_mar    = 1'b1;
                ctrl.gate_sel  = GATE_PC;
                ctrl.ld_pc     = 1'b1;
                ctrl.pcmux_sel = PCMUX_INC;
            end
            S_F2, S_LD2: begin
                ctrl.mem_en = 1'b1;
                ctrl.ld_mdr = 1'b1;
            end
            S_F3: begin
                ctrl.ld_ir    = 1'b1;
                ctrl.gate_sel = GATE_MDR;
            end
            S_ALU: begin
                ctrl.reg_we   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.gate_sel = GATE_ALU;
                case (ir[15:12])
                    OP_AND:  ctrl.alu_op = ALU_AND;
                    OP_NOT:  ctrl.alu_op = ALU_NOT;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_LEA: begin
                ctrl.reg_we     = 1'b1;
                ctrl.gate_sel   = GATE_MARMUX;
                ctrl.marmux_sel = MARMUX_OFF9;
            end
            S_LD1, S_ST1: begin
                ctrl.ld_mar     = 1'b1;
                ctrl.gate_sel   = GATE_MARMUX;
                ctrl.marmux_sel = MARMUX_OFF9;
            end
            S_LD3: begin
                ctrl.reg_we   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.gate_sel = GATE_MDR;
            end
            S_ST2: begin
                // Store source register sits in the DR field of the ST encoding.
                ctrl.sr1      = ir[11:9];
                ctrl.ld_mdr   = 1'b1;
                ctrl.alu_op   = ALU_PASSA;
                ctrl.gate_sel = GATE_ALU;
            end
            S_ST3: begin
                ctrl.mem_en = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            S_BR: begin
                if (br_taken) begin
                    ctrl.ld_pc     = 1'b1;
                    ctrl.pcmux_sel = PCMUX_OFF9;
                end
            end
            S_JMP: begin
                ctrl.ld_pc     = 1'b1;
                ctrl.pcmux_sel = PCMUX_BASER;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multicycle control unit: owns the fetch/decode/execute state
// sequence; the control word is decoded from state and IR by a sub-block.
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [IR_W-1:0]    ir,
    input  logic               cc_n,
    input  logic               cc_z,
    input  logic               cc_p,
    input  logic               mem_ready,
    output logic               ld_pc,
    output logic               ld_mar,
    output logic               ld_mdr,
    output logic               ld_ir,
    output logic               ld_cc,
    output logic               reg_we,
    output logic [REG_AW-1:0]  dr,
    output logic [REG_AW-1:0]  sr1,
    output logic [REG_AW-1:0]  sr2,
    output logic [SEL_W-1:0]   gate_sel,
    output logic [SEL_W-1:0]   pcmux_sel,
    output logic               marmux_sel,
    output logic [SEL_W-1:0]   alu_op,
    output logic               mem_en,
    output logic               mem_we,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    state_t state_done;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Where every instruction goes after its last state.
    assign state_done = run ? S_F1 : S_IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   if (mem_ready) state_d = S_F3;
            S_F3:   state_d = S_DEC;
            S_DEC:  state_d = dispatch(ir[15:12]);
            S_LD1:  state_d = S_LD2;
            S_LD2:  if (mem_ready) state_d = S_LD3;
            S_ST1:  state_d = S_ST2;
            S_ST2:  state_d = S_ST3;
            S_ST3:  if (mem_ready) state_d = state_done;
            S_ALU, S_LEA, S_LD3, S_BR, S_JMP: state_d = state_done;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    lc3_ctrl_fsm_decode u_decode (
        .state (state_q),
        .ir    (ir),
        .cc_n  (cc_n),
        .cc_z  (cc_z),
        .cc_p  (cc_p),
        .ctrl  (ctrl)
    );

    assign ld_pc      = ctrl.ld_pc;
    assign ld_mar     = ctrl.ld_mar;
    assign ld_mdr     = ctrl.ld_mdr;
    assign ld_ir      = ctrl.ld_ir;
    assign ld_cc      = ctrl.ld_cc;
    assign reg_we     = ctrl.reg_we;
    assign dr         = ctrl.dr;
    assign sr1        = ctrl.sr1;
    assign sr2        = ctrl.sr2;
    assign gate_sel   = ctrl.gate_sel;
    assign pcmux_sel  = ctrl.pcmux_sel;
    assign marmux_sel = ctrl.marmux_sel;
    assign alu_op     = ctrl.alu_op;
    assign mem_en     = ctrl.mem_en;
    assign mem_we     = ctrl.mem_we;
    assign halted     = ctrl.halted;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: vector table of single instructions scored
// through an expectation queue, plus hand sequences for waits, reset and halt.
module tb_lc3_ctrl_fsm;

    localparam logic [3:0] T_IDLE = 4'd0,  T_F1  = 4'd1,  T_F2  = 4'd2;
    localparam logic [3:0] T_ALU  = 4'd5,  T_LEA = 4'd6,  T_LD2 = 4'd8;
    localparam logic [3:0] T_LD3  = 4'd9,  T_ST1 = 4'd10, T_ST2 = 4'd11;
    localparam logic [3:0] T_ST3  = 4'd12, T_BR  = 4'd13, T_JMP = 4'd14;
    localparam logic [3:0] T_HALT = 4'd15;

    logic        clk = 1'b0;
    logic        rst, run, cc_n, cc_z, cc_p, mem_ready;
    logic [15:0] ir;
    logic        ld_pc, ld_mar, ld_mdr, ld_ir, ld_cc, reg_we;
    logic [2:0]  dr, sr1, sr2;
    logic [1:0]  gate_sel, pcmux_sel, alu_op;
    logic        marmux_sel, mem_en, mem_we, halted;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    lc3_ctrl_fsm dut (
        .clk(clk), .rst(rst), .run(run), .ir(ir),
        .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p), .mem_ready(mem_ready),
        .ld_pc(ld_pc), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
        .ld_cc(ld_cc), .reg_we(reg_we), .dr(dr), .sr1(sr1), .sr2(sr2),
        .gate_sel(gate_sel), .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel),
        .alu_op(alu_op), .mem_en(mem_en), .mem_we(mem_we), .halted(halted),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  cc;      // {n,z,p}
        logic [3:0]  last;
        int          cycles;  // F1 through last state, zero-wait memory
        logic [24:0] out;
    } vec_t;

    vec_t vecs[11];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] obs();
        return {ld_pc, ld_mar, ld_mdr, ld_ir, ld_cc, reg_we, dr, sr1, sr2,
                gate_sel, pcmux_sel, marmux_sel, alu_op, mem_en, mem_we, halted};
    endfunction

    function automatic logic [24:0] mk(
        input logic lpc, input logic lmdr, input logic lcc, input logic we,
        input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
        input logic [1:0] g, input logic [1:0] pm, input logic mm,
        input logic [1:0] op, input logic me, input logic mw);
        return {lpc, 1'b0, lmdr, 1'b0, lcc, we, d, s1, s2, g, pm, mm, op, me, mw, 1'b0};
    endfunction

    task automatic wait_state(input logic [3:0] s, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n++;
            if (state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        vec_t e;

        vecs[0]  = '{16'h1283, 3'b000, T_ALU, 5, mk(0,0,1,1, 3'd1,3'd2,3'd3, 2'd2,2'd0,0,2'd0, 0,0)};
        vecs[1]  = '{16'h5A47, 3'b000, T_ALU, 5, mk(0,0,1,1, 3'd5,3'd1,3'd7, 2'd2,2'd0,0,2'd1, 0,0)};
        vecs[2]  = '{16'h967F, 3'b000, T_ALU, 5, mk(0,0,1,1, 3'd3,3'd1,3'd7, 2'd2,2'd0,0,2'd2, 0,0)};
        vecs[3]  = '{16'hE1FE, 3'b111, T_LEA, 5, mk(0,0,0,1, 3'd0,3'd7,3'd6, 2'd3,2'd0,0,2'd0, 0,0)};
        vecs[4]  = '{16'h0402, 3'b010, T_BR,  5, mk(1,0,0,0, 3'd2,3'd0,3'd2, 2'd0,2'd1,0,2'd0, 0,0)};
        vecs[5]  = '{16'h0402, 3'b001, T_BR,  5, mk(0,0,0,0, 3'd2,3'd0,3'd2, 2'd0,2'd0,0,2'd0, 0,0)};
        vecs[6]  = '{16'h0E00, 3'b100, T_BR,  5, mk(1,0,0,0, 3'd7,3'd0,3'd0, 2'd0,2'd1,0,2'd0, 0,0)};
        vecs[7]  = '{16'h0800, 3'b011, T_BR,  5, mk(0,0,0,0, 3'd4,3'd0,3'd0, 2'd0,2'd0,0,2'd0, 0,0)};
        vecs[8]  = '{16'hC1C0, 3'b000, T_JMP, 5, mk(1,0,0,0, 3'd0,3'd7,3'd0, 2'd0,2'd2,0,2'd0, 0,0)};
        vecs[9]  = '{16'h2405, 3'b000, T_LD3, 7, mk(0,0,1,1, 3'd2,3'd0,3'd5, 2'd1,2'd0,0,2'd0, 0,0)};
        vecs[10] = '{16'h3605, 3'b000, T_ST3, 7, mk(0,0,0,0, 3'd3,3'd0,3'd5, 2'd0,2'd0,0,2'd0, 1,1)};

        // Reset state with a non-zero IR applied
        rst = 1'b0; run = 1'b0; ir = 16'h1283; mem_ready = 1'b1;
        {cc_n, cc_z, cc_p} = 3'b000;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'(T_IDLE));
        check("reset_outputs", 32'(obs()), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_run", 32'(state), 32'(T_IDLE));

        // Single-instruction vectors, run dropped after F1
        for (int i = 0; i < 11; i++) begin
            ir = vecs[i].ir;
            {cc_n, cc_z, cc_p} = vecs[i].cc;
            mem_ready = 1'b1;
            run = 1'b1;
            exp_q.push_back(vecs[i]);
            wait_state(T_F1, 4, n, ok);
            check($sformatf("v%0d_reach_f1", i), 32'(ok), 32'd1);
            run = 1'b0;
            wait_state(vecs[i].last, 20, n, ok);
            e = exp_q.pop_front();
            check($sformatf("v%0d_reach_last", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_cycles", i), 32'(n + 1), 32'(e.cycles));
            check($sformatf("v%0d_ctrl", i), 32'(obs()), 32'(e.out));
            @(negedge clk);
            check($sformatf("v%0d_back_idle", i), 32'(state), 32'(T_IDLE));
        end

        // LD with three wait cycles in LD2
        ir = 16'h2405; run = 1'b1; mem_ready = 1'b1;
        wait_state(T_F1, 4, n, ok);
        run = 1'b0;
        wait_state(T_LD2, 10, n, ok);
        check("ld_reach_ld2", 32'(ok), 32'd1);
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("ld2_wait%0d_state", k), 32'(state), 32'(T_LD2));
            check($sformatf("ld2_wait%0d_mem", k), 32'({mem_en, mem_we, ld_mdr}), 32'b101);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("ld3_state", 32'(state), 32'(T_LD3));
        check("ld3_we_dr_gate", 32'({reg_we, ld_cc, dr, gate_sel}), 32'({1'b1, 1'b1, 3'd2, 2'd1}));
        @(negedge clk);
        check("ld_idle", 32'(state), 32'(T_IDLE));

        // ST with fetch wait and store wait; mem_ready low in ST1 is ignored
        ir = 16'h3605; run = 1'b1; mem_ready = 1'b0;
        wait_state(T_F1, 4, n, ok);
        run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("f2_wait%0d", k), 32'({state, mem_en, ld_mdr}), 32'({T_F2, 1'b1, 1'b1}));
        end
        mem_ready = 1'b1;
        wait_state(T_ST1, 6, n, ok);
        check("st_reach_st1", 32'(ok), 32'd1);
        mem_ready = 1'b0;
        @(negedge clk);
        check("st2_state", 32'(state), 32'(T_ST2));
        check("st2_ctrl", 32'({sr1, alu_op, ld_mdr, gate_sel}), 32'({3'd3, 2'd3, 1'b1, 2'd2}));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("st3_wait%0d", k), 32'({state, mem_en, mem_we}), 32'({T_ST3, 1'b1, 1'b1}));
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("st_idle", 32'(state), 32'(T_IDLE));

        // ADD with run held continues straight into the next fetch
        ir = 16'h1283; run = 1'b1;
        wait_state(T_ALU, 10, n, ok);
        check("cont_reach_alu", 32'(ok), 32'd1);
        @(negedge clk);
        check("cont_next_f1", 32'(state), 32'(T_F1));
        run = 1'b0;
        wait_state(T_IDLE, 10, n, ok);
        check("cont_back_idle", 32'(ok), 32'd1);

        // Reset in the middle of a stalled fetch
        run = 1'b1; mem_ready = 1'b0;
        wait_state(T_F2, 6, n, ok);
        @(negedge clk);
        check("rst_mid_f2", 32'({state, mem_en}), 32'({T_F2, 1'b1}));
        rst = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'(T_IDLE));
        check("rst_async_outputs", 32'(obs()), 32'h0);
        @(negedge clk);
        check("rst_held_outputs", 32'({state, obs()}), 32'h0);
        run = 1'b0; rst = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", k), 32'(state), 32'(T_IDLE));
        end

        // TRAP halts until reset, whatever run does
        ir = 16'hF025; run = 1'b1;
        wait_state(T_HALT, 10, n, ok);
        check("trap_reach_halt", 32'(ok), 32'd1);
        for (int k = 0; k < 10; k++) begin
            run = k[0];
            @(negedge clk);
            check($sformatf("halt%0d", k), 32'({state, halted, mem_en, reg_we}), 32'({T_HALT, 1'b1, 1'b0, 1'b0}));
        end
        rst = 1'b0;
        #1;
        check("halt_rst", 32'({state, halted}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
